// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
//
// Steps the shared neuron datapath through one forward pass. It visits every
// hidden neuron and then every output neuron. For each neuron it presents the
// weight-RAM base address, waits out the RAM latency, and then latches the
// neuron result into a result bank. The caller sees a start/busy/done
// handshake.
//
// Ports
//   Clock        in   rising-edge clock
//   Rst          in   asynchronous active-low reset
//   start        in   begin a pass (only looked at in IDLE)
//   abort        in   synchronous cancel of a running pass
//   neuron_out   in   DW     result from the shared neuron datapath
//   wt_addr      out  AW     weight-RAM base address of the current neuron
//   layer_sel    out  1      0 = hidden layer, 1 = output layer
//   neuron_idx   out  3      neuron index within the current layer
//   busy         out  1      pass in progress
//   done         out  1      one-cycle completion pulse
//   hid_vals     out  N_HID*DW  hidden results, slot i at [i*DW +: DW]
//   out_vals     out  N_OUT*DW  output results, same packing
//   pass_cycles  out  16     busy cycles of the current/last pass
//                            (present only when SEQ_PERF_CNT_EN is defined)
//
// Build option: define SEQ_PERF_CNT_EN to add the pass_cycles counter.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start, outputs parked at 0
//   ADDR   | wt_addr presented for the current neuron
//   WAIT   | RAM latency countdown, wt_addr held
//   CAPT   | neuron_out latched into the result bank
//   DONE   | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module nn_layer_sequencer #(
  parameter int N_IN     = 10,
  parameter int N_HID    = 5,
  parameter int N_OUT    = 3,
  parameter int HID_BASE = 0,
  parameter int OUT_BASE = 50,
  parameter int RAM_LAT  = 1,
  parameter int AW       = 7,
  parameter int DW       = 10
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DW-1:0]       neuron_out,
  output logic [AW-1:0]       wt_addr,
  output logic                layer_sel,
  output logic [2:0]          neuron_idx,
  output logic                busy,
  output logic                done,
  output logic [N_HID*DW-1:0] hid_vals,
  output logic [N_OUT*DW-1:0] out_vals
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]         pass_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  localparam int WCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(RAM_LAT - 1);

  localparam logic [2:0]    LAST_HID   = 3'(N_HID - 1);
  localparam logic [2:0]    LAST_OUT   = 3'(N_OUT - 1);
  localparam logic [AW-1:0] HID_BASE_A = AW'(HID_BASE);
  localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);
  localparam logic [AW-1:0] N_IN_A     = AW'(N_IN);
  localparam logic [AW-1:0] N_HID_A    = AW'(N_HID);

  state_t               state_q, state_d;
  logic [WCW-1:0]       wait_q, wait_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 layer_q, layer_d;
  logic [2:0]           idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [N_HID*DW-1:0]  hid_q, hid_d;
  logic [N_OUT*DW-1:0]  out_q, out_d;
  logic                 run_abort;
  logic                 start_acc;

  // Abort only matters while a pass is running; in IDLE it also masks start.
  assign run_abort = abort && ((state_q == S_ADDR) || (state_q == S_WAIT) ||
                               (state_q == S_CAPT));
  assign start_acc = (state_q == S_IDLE) && start && !abort;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    layer_d = layer_q;
    idx_d   = idx_q;
    hid_d   = hid_q;
    out_d   = out_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_ADDR;
          layer_d = 1'b0;
          idx_d   = 3'd0;
        end
      end
      S_ADDR: begin
        state_d = S_WAIT;
        wait_d  = WAIT_LOAD;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_CAPT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_CAPT: begin
        // An abort in this cycle also drops the capture.
        if (!abort) begin
          if (!layer_q) begin
            for (int i = 0; i < N_HID; i++) begin
              if (idx_q == 3'(i)) hid_d[i*DW +: DW] = neuron_out;
            end
          end else begin
            for (int i = 0; i < N_OUT; i++) begin
              if (idx_q == 3'(i)) out_d[i*DW +: DW] = neuron_out;
            end
          end
        end
        if (!layer_q && (idx_q == LAST_HID)) begin
          layer_d = 1'b1;
          idx_d   = 3'd0;
          state_d = S_ADDR;
        end else if (layer_q && (idx_q == LAST_OUT)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (run_abort) begin
      state_d = S_IDLE;
    end

    // Outputs are registered, so they are derived from the next state.
    case (state_d)
      S_ADDR: begin
        busy_d = 1'b1;
        if (layer_d) begin
          addr_d = OUT_BASE_A + AW'(idx_d) * N_HID_A;
        end else begin
          addr_d = HID_BASE_A + AW'(idx_d) * N_IN_A;
        end
      end
      S_WAIT, S_CAPT: begin
        busy_d = 1'b1;
      end
      default: begin
        // IDLE and DONE park the address, layer and index at 0.
        addr_d  = '0;
        layer_d = 1'b0;
        idx_d   = 3'd0;
        done_d  = (state_d == S_DONE);
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      layer_q <= 1'b0;
      idx_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hid_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      layer_q <= layer_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hid_q   <= hid_d;
      out_q   <= out_d;
    end
  end

  assign wt_addr    = addr_q;
  assign layer_sel  = layer_q;
  assign neuron_idx = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hid_vals   = hid_q;
  assign out_vals   = out_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  // busy_q is high for exactly the busy cycles of the pass, so counting on
  // it makes the value freeze by itself once DONE or an abort drops busy.
  always_comb begin
    cyc_d = cyc_q;
    if (start_acc) begin
      cyc_d = 16'd0;
    end else if (busy_q && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      cyc_q <= 16'd0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign pass_cycles = cyc_q;
`endif

endmodule
